alu_ctrl_pipe: RTL and testbench

Registered, parametrised ALU controller for the pipelined CPU's ID/EX boundary. Decodes funct_i and ALUOp_i into the 5-bit ALU operation code using the standard project mapping, and flags illegal encodings. Sequences multi-cycle multiply (MUL) operations, holding the operation code for MUL_CYCLES cycles. Provides a valid/ready handshake with stall and flush support for the hazard unit.

---
 rtl/alu_ctrl_pkg.sv | 56 +++++
 rtl/alu_ctrl_decode.sv | 51 +++++
 rtl/alu_ctrl_pipe.sv | 115 +++++++++++
 tb/tb_alu_ctrl_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU controller.
// Holds the 5-bit ALU operation codes, the ALUOp classes produced by the
// main decoder, the R-type funct values, and the controller FSM state type.
package alu_ctrl_pkg;

    // ALU operation codes (5 bits, zero-extended at the controller output)
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDI = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_ANDI = 5'd6;
    localparam logic [4:0] ALU_LW   = 5'd7;
    localparam logic [4:0] ALU_ORI  = 5'd8;
    localparam logic [4:0] ALU_SLTI = 5'd9;
    localparam logic [4:0] ALU_SW   = 5'd10;
    localparam logic [4:0] ALU_SRL  = 5'd11;
    localparam logic [4:0] ALU_SRLV = 5'd12;
    localparam logic [4:0] ALU_BEQ  = 5'd13;
    localparam logic [4:0] ALU_BNE  = 5'd14;
    localparam logic [4:0] ALU_BGT  = 5'd15;
    localparam logic [4:0] ALU_MUL  = 5'd16;
    localparam logic [4:0] ALU_BGE  = 5'd17;
    localparam logic [4:0] ALU_BLT  = 5'd18;

    // ALUOp classes from the main decoder
    localparam int OP_RTYPE = 0;
    localparam int OP_LW    = 1;
    localparam int OP_ADDI  = 2;
    localparam int OP_ANDI  = 3;
    localparam int OP_ORI   = 4;
    localparam int OP_SLTI  = 5;
    localparam int OP_SW    = 6;
    localparam int OP_BEQ   = 7;
    localparam int OP_BNE   = 8;
    localparam int OP_BGT   = 9;
    localparam int OP_BGE   = 10;
    localparam int OP_BLT   = 11;

    // R-type funct field values
    localparam int F_ADD  = 32;
    localparam int F_SUB  = 34;
    localparam int F_AND  = 36;
    localparam int F_OR   = 37;
    localparam int F_SLT  = 42;
    localparam int F_SRL  = 2;
    localparam int F_SRLV = 6;
    localparam int F_MUL  = 24;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {ALUOp, funct} into a 5-bit ALU operation code.
// Ports:
//   funct_i   - R-type function field
//   ALUOp_i   - operation class from the main decoder
//   code_o    - decoded ALU operation code (0 for illegal encodings)
//   illegal_o - encoding not present in the decode table
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 4
) (
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [OP_W-1:0]    ALUOp_i,
    output logic [4:0]         code_o,
    output logic               illegal_o
);

    always_comb begin
        code_o    = ALU_ADD;
        illegal_o = 1'b0;
        case (ALUOp_i)
            OP_W'(OP_RTYPE): begin
                case (funct_i)
                    FUNCT_W'(F_ADD):  code_o = ALU_ADD;
                    FUNCT_W'(F_SUB):  code_o = ALU_SUB;
                    FUNCT_W'(F_AND):  code_o = ALU_AND;
                    FUNCT_W'(F_OR):   code_o = ALU_OR;
                    FUNCT_W'(F_SLT):  code_o = ALU_SLT;
                    FUNCT_W'(F_SRL):  code_o = ALU_SRL;
                    FUNCT_W'(F_SRLV): code_o = ALU_SRLV;
                    FUNCT_W'(F_MUL):  code_o = ALU_MUL;
                    default:          illegal_o = 1'b1;
                endcase
            end
            OP_W'(OP_LW):   code_o = ALU_LW;
            OP_W'(OP_ADDI): code_o = ALU_ADDI;
            OP_W'(OP_ANDI): code_o = ALU_ANDI;
            OP_W'(OP_ORI):  code_o = ALU_ORI;
            OP_W'(OP_SLTI): code_o = ALU_SLTI;
            OP_W'(OP_SW):   code_o = ALU_SW;
            OP_W'(OP_BEQ):  code_o = ALU_BEQ;
            OP_W'(OP_BNE):  code_o = ALU_BNE;
            OP_W'(OP_BGT):  code_o = ALU_BGT;
            OP_W'(OP_BGE):  code_o = ALU_BGE;
            OP_W'(OP_BLT):  code_o = ALU_BLT;
            default:        illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU controller at the ID/EX boundary.
// Decodes the instruction, sequences multi-cycle MUL, and offers a
// valid/ready handshake with stall and flush for the hazard unit.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous reset, active-low
//   funct_i   - R-type function field
//   ALUOp_i   - operation class
//   valid_i   - inputs carry a real instruction
//   stall_i   - freeze all state
//   flush_i   - squash in-flight operation (overrides stall)
//   ready_o   - controller can accept (IDLE and not stalled)
//   ALUCtrl_o - registered ALU operation code
//   valid_o   - ALUCtrl_o is a live operation
//   last_o    - final EX cycle of the current operation
//   illegal_o - accepted encoding not in the decode table
//   busy_o    - multi-cycle MUL in progress
module alu_ctrl_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_W    = 6,
    parameter int OP_W       = 4,
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic [OP_W-1:0]    ALUOp_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic [CTRL_W-1:0]  ALUCtrl_o,
    output logic               valid_o,
    output logic               last_o,
    output logic               illegal_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    // With a single-cycle multiplier MUL is treated like any other code.
    localparam bit MULTI = (MUL_CYCLES > 1);

    logic [4:0]        dec_code;
    logic              dec_illegal;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic              valid_reg;
    logic              last_reg;
    logic              illegal_reg;
    logic              busy_reg;

    alu_ctrl_decode #(
        .FUNCT_W (FUNCT_W),
        .OP_W    (OP_W)
    ) u_decode (
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .code_o    (dec_code),
        .illegal_o (dec_illegal)
    );

    assign ready_o   = (state_reg == IDLE) && !stall_i;
    assign ALUCtrl_o = ctrl_reg;
    assign valid_o   = valid_reg;
    assign last_o    = last_reg;
    assign illegal_o = illegal_reg;
    assign busy_o    = busy_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ctrl_reg    <= '0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else if (stall_i) begin
            // hold everything
        end else if (state_reg == MUL && cnt_reg != '0) begin
            // Code, valid and illegal stay put while the multiplier runs.
            cnt_reg  <= cnt_reg - CNT_W'(1);
            last_reg <= (cnt_reg == CNT_W'(1));
        end else begin
            // IDLE, or the edge that leaves MUL: this edge takes new input
            // because the upstream stage has been holding its instruction.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            if (valid_i) begin
                ctrl_reg    <= CTRL_W'(dec_code);
                valid_reg   <= 1'b1;
                illegal_reg <= dec_illegal;
                if (MULTI && dec_code == ALU_MUL) begin
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b1;
                    cnt_reg   <= CNT_W'(MUL_CYCLES - 1);
                    state_reg <= MUL;
                end else begin
                    last_reg  <= 1'b1;
                end
            end else begin
                ctrl_reg    <= '0;
                valid_reg   <= 1'b0;
                last_reg    <= 1'b0;
                illegal_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] funct_i;
    logic [3:0] ALUOp_i;
    logic       valid_i;
    logic       stall_i;
    logic       flush_i;

    logic       ready_o,  valid_o,  last_o,  illegal_o,  busy_o;
    logic [4:0] ALUCtrl_o;
    logic       ready1,   valid1,   last1,   illegal1,   busy1;
    logic [4:0] ctrl1;

    int n_cmp = 0;
    int n_err = 0;
    int occ;

    always #5 clk_i = ~clk_i;

    alu_ctrl_pipe #(.MUL_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .ready_o(ready_o), .ALUCtrl_o(ALUCtrl_o), .valid_o(valid_o),
        .last_o(last_o), .illegal_o(illegal_o), .busy_o(busy_o)
    );

    alu_ctrl_pipe #(.MUL_CYCLES(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .ready_o(ready1), .ALUCtrl_o(ctrl1), .valid_o(valid1),
        .last_o(last1), .illegal_o(illegal1), .busy_o(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input int ctrl, input int vld,
                             input int lst, input int ill, input int bsy);
        check({tag, ".ctrl"},    32'(ALUCtrl_o), ctrl);
        check({tag, ".valid"},   32'(valid_o),   vld);
        check({tag, ".last"},    32'(last_o),    lst);
        check({tag, ".illegal"}, 32'(illegal_o), ill);
        check({tag, ".busy"},    32'(busy_o),    bsy);
    endtask

    initial begin
        // 1. reset with a live instruction present
        rst_i = 1'b0; valid_i = 1'b1; ALUOp_i = 4'd1; funct_i = 6'd0;
        stall_i = 1'b0; flush_i = 1'b0;
        tick(); tick();
        check_out("reset", 0, 0, 0, 0, 0);
        rst_i = 1'b1; valid_i = 1'b0;
        #1;
        check("reset.ready", 32'(ready_o), 1);

        // 2. single-cycle decodes and bubble
        valid_i = 1'b1; ALUOp_i = 4'd0; funct_i = 6'd34;
        tick();
        check_out("sub", 2, 1, 1, 0, 0);
        ALUOp_i = 4'd11;
        tick();
        check_out("blt", 18, 1, 1, 0, 0);
        valid_i = 1'b0;
        tick();
        check_out("bubble", 0, 0, 0, 0, 0);

        // 3. MUL for 4 cycles, then back-to-back add
        valid_i = 1'b1; ALUOp_i = 4'd0; funct_i = 6'd24;
        tick();
        check_out("mul.c1", 16, 1, 0, 0, 1);
        funct_i = 6'd32;
        #1;
        check("mul.c1.ready", 32'(ready_o), 0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_out($sformatf("mul.c%0d", c), 16, 1, (c == 4) ? 1 : 0, 0, 1);
            check($sformatf("mul.c%0d.ready", c), 32'(ready_o), 0);
        end
        tick();
        check_out("mul.add", 0, 1, 1, 0, 0);
        check("mul.add.ready", 32'(ready_o), 1);
        valid_i = 1'b0;
        tick();
        check_out("mul.bubble", 0, 0, 0, 0, 0);

        // 4. MUL with 3 stall cycles mid-operation: 7 busy cycles total
        occ = 0;
        valid_i = 1'b1; funct_i = 6'd24;
        tick(); if (busy_o) occ++;
        valid_i = 1'b0;
        tick(); if (busy_o) occ++;
        stall_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick(); if (busy_o) occ++;
            check($sformatf("stall%0d.ctrl", s), 32'(ALUCtrl_o), 16);
            check($sformatf("stall%0d.last", s), 32'(last_o), 0);
        end
        stall_i = 1'b0;
        for (int k = 0; k < 10 && busy_o; k++) begin
            tick(); if (busy_o) occ++;
        end
        check("stall.occupancy", 32'(occ), 7);
        check_out("stall.after", 0, 0, 0, 0, 0);

        // 5. flush with simultaneous stall in MUL cycle 2
        valid_i = 1'b1; funct_i = 6'd24;
        tick();
        valid_i = 1'b0;
        tick();
        check("flush.pre.busy", 32'(busy_o), 1);
        flush_i = 1'b1; stall_i = 1'b1; valid_i = 1'b1; funct_i = 6'd32;
        tick();
        flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
        #1;
        check_out("flush", 0, 0, 0, 0, 0);
        check("flush.ready", 32'(ready_o), 1);

        // 6. illegal encodings, stall hold in IDLE, single-cycle MUL
        valid_i = 1'b1; ALUOp_i = 4'd0; funct_i = 6'd5;
        tick();
        check_out("ill.funct", 0, 1, 1, 1, 0);
        ALUOp_i = 4'd13;
        tick();
        check_out("ill.op", 0, 1, 1, 1, 0);
        ALUOp_i = 4'd1;
        tick();
        check_out("lw", 7, 1, 1, 0, 0);
        stall_i = 1'b1; ALUOp_i = 4'd11;
        tick();
        check("idle.stall.ctrl", 32'(ALUCtrl_o), 7);
        check("idle.stall.ready", 32'(ready_o), 0);
        stall_i = 1'b0; ALUOp_i = 4'd0; funct_i = 6'd24;
        tick();
        check("mul1.ctrl",  32'(ctrl1),  16);
        check("mul1.valid", 32'(valid1), 1);
        check("mul1.last",  32'(last1),  1);
        check("mul1.busy",  32'(busy1),  0);
        check("mul1.ready", 32'(ready1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
